// File: rtl/cnt_updn_n.sv
// Presettable synchronous up/down counter with optional modulus, cascadable
// ripple carry/borrow and a sticky wrap flag.
module cnt_updn_n #(
  parameter int WIDTH   = 8,
  parameter int MOD_VAL = 0
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             SCLR_n,
  input  logic             LD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             OVF
);

  localparam int TOP_INT = (MOD_VAL != 0) ? (MOD_VAL - 1) : ((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] TOP = TOP_INT[WIDTH-1:0];

  logic [WIDTH-1:0] q_next;
  logic             ovf_next;

  always_comb begin
    q_next   = Q;
    ovf_next = OVF;
    if (!SCLR_n) begin
      q_next   = '0;
      ovf_next = 1'b0;
    end else if (!LD_n) begin
      q_next = D;
    end else if (ENP && ENT) begin
      if (UP) begin
        if (Q >= TOP) begin
          q_next   = '0;
          ovf_next = 1'b1;
        end else begin
          q_next = Q + 1'b1;
        end
      end else begin
        // An out-of-range value left by a load re-enters at TOP without flagging a wrap.
        if (Q == '0) begin
          q_next   = TOP;
          ovf_next = 1'b1;
        end else if (Q > TOP) begin
          q_next = TOP;
        end else begin
          q_next = Q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      Q   <= '0;
      OVF <= 1'b0;
    end else begin
      Q   <= q_next;
      OVF <= ovf_next;
    end
  end

  // Terminal count depends only on Q, ENT and UP so stages cascade without extra gating.
  assign RCO = ENT & (UP ? (Q == TOP) : (Q == '0));

endmodule

// File: tb/tb_cnt_updn_n.sv
// Directed bench: a modulo-10 4-bit counter plus a two-stage 8-bit cascade.
module tb_cnt_updn_n;

  logic       clk;
  int         errors;
  int         checks;

  // Modulo-10, 4-bit counter
  logic       clr_n, sclr_n, ld_n, enp, ent, up;
  logic [3:0] d, q;
  logic       rco, ovf;

  // Cascade of two natural-wrap 4-bit stages
  logic       c_clr_n, c_enp, c_up;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco, lo_ovf, hi_ovf;

  cnt_updn_n #(.WIDTH(4), .MOD_VAL(10)) dut (
    .CLK(clk), .CLR_n(clr_n), .SCLR_n(sclr_n), .LD_n(ld_n), .ENP(enp),
    .ENT(ent), .UP(up), .D(d), .Q(q), .RCO(rco), .OVF(ovf)
  );

  cnt_updn_n #(.WIDTH(4), .MOD_VAL(0)) lo (
    .CLK(clk), .CLR_n(c_clr_n), .SCLR_n(1'b1), .LD_n(1'b1), .ENP(c_enp),
    .ENT(1'b1), .UP(c_up), .D(4'd0), .Q(lo_q), .RCO(lo_rco), .OVF(lo_ovf)
  );

  cnt_updn_n #(.WIDTH(4), .MOD_VAL(0)) hi (
    .CLK(clk), .CLR_n(c_clr_n), .SCLR_n(1'b1), .LD_n(1'b1), .ENP(c_enp),
    .ENT(lo_rco), .UP(c_up), .D(4'd0), .Q(hi_q), .RCO(hi_rco), .OVF(hi_ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    clr_n   = 1'b1;
    sclr_n  = 1'b1;
    ld_n    = 1'b1;
    enp     = 1'b0;
    ent     = 1'b0;
    up      = 1'b1;
    d       = 4'd0;
    c_clr_n = 1'b1;
    c_enp   = 1'b0;
    c_up    = 1'b1;
    #2;
    clr_n   = 1'b0;
    c_clr_n = 1'b0;
    #1;
    chk("reset_q", 16'(q), 16'd0);
    chk("reset_ovf", 16'(ovf), 16'd0);
    ent = 1'b1;
    up  = 1'b0;
    #1;
    chk("reset_rco_down", 16'(rco), 16'd1);
    up = 1'b1;
    #1;
    chk("reset_rco_up", 16'(rco), 16'd0);

    // Synchronous inputs ignored while held in reset
    ld_n = 1'b0;
    d    = 4'd5;
    enp  = 1'b1;
    step();
    chk("reset_ignore_ld", 16'(q), 16'd0);

    // Up count from reset, wrap at 9
    ld_n    = 1'b1;
    clr_n   = 1'b1;
    c_clr_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("up_q", 16'(q), 16'(i % 10));
      chk("up_rco", 16'(rco), 16'((i % 10) == 9));
      chk("up_ovf", 16'(ovf), 16'(i >= 10));
    end

    // Down count from reset
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
    up    = 1'b0;
    #1;
    chk("down_rco_at0", 16'(rco), 16'd1);
    chk("down_ovf_pre", 16'(ovf), 16'd0);
    step();
    chk("down_q9", 16'(q), 16'd9);
    chk("down_ovf", 16'(ovf), 16'd1);
    chk("down_rco9", 16'(rco), 16'd0);
    step();
    chk("down_q8", 16'(q), 16'd8);
    step();
    chk("down_q7", 16'(q), 16'd7);
    chk("down_ovf_sticky", 16'(ovf), 16'd1);

    // Out-of-range load
    sclr_n = 1'b0;
    step();
    chk("sclr_q", 16'(q), 16'd0);
    chk("sclr_ovf", 16'(ovf), 16'd0);
    sclr_n = 1'b1;
    ld_n   = 1'b0;
    d      = 4'd13;
    step();
    chk("load13_q", 16'(q), 16'd13);
    chk("load13_ovf", 16'(ovf), 16'd0);
    ld_n = 1'b1;
    step();
    chk("oor_down_q", 16'(q), 16'd9);
    chk("oor_down_ovf", 16'(ovf), 16'd0);
    ld_n = 1'b0;
    step();
    chk("reload13_q", 16'(q), 16'd13);
    ld_n = 1'b1;
    up   = 1'b1;
    step();
    chk("oor_up_q", 16'(q), 16'd0);
    chk("oor_up_ovf", 16'(ovf), 16'd1);
    ld_n = 1'b0;
    d    = 4'd4;
    step();
    chk("load_keeps_ovf_q", 16'(q), 16'd4);
    chk("load_keeps_ovf", 16'(ovf), 16'd1);

    // Priority: clear over load over count
    sclr_n = 1'b0;
    ld_n   = 1'b0;
    d      = 4'd5;
    enp    = 1'b1;
    ent    = 1'b1;
    step();
    chk("prio_sclr_q", 16'(q), 16'd0);
    chk("prio_sclr_ovf", 16'(ovf), 16'd0);
    sclr_n = 1'b1;
    step();
    chk("prio_ld_q", 16'(q), 16'd5);
    ent  = 1'b0;
    ld_n = 1'b1;
    step();
    chk("hold_ent_q", 16'(q), 16'd5);
    chk("hold_ent_rco", 16'(rco), 16'd0);

    // RCO independent of ENP; direction change is immediate
    ld_n = 1'b0;
    d    = 4'd9;
    step();
    ld_n = 1'b1;
    enp  = 1'b0;
    ent  = 1'b1;
    up   = 1'b1;
    #1;
    chk("rco_no_enp", 16'(rco), 16'd1);
    step();
    chk("hold_enp_q", 16'(q), 16'd9);
    up = 1'b0;
    #1;
    chk("rco_dir_comb", 16'(rco), 16'd0);
    enp = 1'b1;
    step();
    chk("dir_same_edge_q", 16'(q), 16'd8);

    // Async reset pulse between edges
    ld_n = 1'b0;
    d    = 4'd7;
    step();
    ld_n = 1'b1;
    up   = 1'b1;
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_q", 16'(q), 16'd0);
    chk("async_ovf", 16'(ovf), 16'd0);
    #1;
    clr_n = 1'b1;
    step();
    chk("after_async_q", 16'(q), 16'd1);

    // Two-stage cascade
    c_up  = 1'b1;
    c_enp = 1'b1;
    repeat (16) step();
    chk("casc_16", {8'd0, hi_q, lo_q}, 16'd16);
    repeat (284) step();
    chk("casc_300", {8'd0, hi_q, lo_q}, 16'd44);
    chk("casc_hi_ovf", 16'(hi_ovf), 16'd1);
    c_up = 1'b0;
    repeat (45) step();
    chk("casc_345", {8'd0, hi_q, lo_q}, 16'd255);
    chk("casc_lo_ovf", 16'(lo_ovf), 16'd1);

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
